// File: rtl/mem_loader.sv
// mem_loader: buffers an image stream and writes it from START_ADDR in 16/8/4/1-word bursts; define LOADER_CHECKSUM_EN to add a checksum output
module mem_loader #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR  = 32'h80020000,
  parameter int                    DEPTH_WORDS = 262144
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  input  logic                  word_last,
  output logic                  word_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [1:0]            mem_access_size,
  output logic                  mem_rw,
  output logic                  mem_enable,
  input  logic                  mem_busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] words_written
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);
  typedef enum logic [2:0] {IDLE, FILL, BURST, FLUSH, DONE, ERR} state_t;
  localparam logic [ADDR_WIDTH:0] limit = {1'b0, START_ADDR} + ((ADDR_WIDTH+1)'(DEPTH_WORDS) << 2);
  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] buffer [16];
  logic [4:0]            cnt, len, len_nx;
  logic [3:0]            rd, beat, rd_idx;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  last_seen, accept, fits, launch, restart, beat_done, burst_end;
  assign restart   = start && (state == IDLE || state == DONE);
  assign accept    = word_valid && state == FILL && cnt < 5'd16;
  assign len_nx    = state != FLUSH ? 5'd16 : cnt >= 5'd8 ? 5'd8 : cnt >= 5'd4 ? 5'd4 : 5'd1;
  assign fits      = ({1'b0, ptr} + ((ADDR_WIDTH+1)'(len_nx) << 2)) <= limit;
  assign launch    = (state == FILL || state == FLUSH) && state_nx == BURST;
  assign beat_done = state == BURST && !mem_busy;
  assign burst_end = beat_done && beat == 4'(len - 5'd1);
  assign rd_idx    = rd + beat;
  // state register
  always_ff @(posedge clock) begin
    state <= reset ? IDLE : state_nx;
  end
  // next state: the overflow check gates every burst launch
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = start ? FILL : state;
      FILL:       state_nx = accept && cnt == 5'd15 ? (fits ? BURST : ERR) : accept && word_last ? FLUSH : FILL;
      BURST:      state_nx = !burst_end ? BURST : !last_seen ? FILL : cnt == len ? DONE : FLUSH;
      FLUSH:      state_nx = cnt == 5'd0 ? DONE : fits ? BURST : ERR;
      default:    state_nx = state;
    endcase
  end
  // outputs decoded from state; mem_* only change on beat completion so a stall freezes them
  always_comb begin
    word_ready      = state == FILL && cnt < 5'd16;
    mem_enable      = state == BURST;
    mem_rw          = state != BURST;
    mem_address     = ptr;
    mem_data_in     = state == BURST ? buffer[rd_idx] : '0;
    mem_access_size = state != BURST ? 2'b00 : len == 5'd16 ? 2'b11 : len == 5'd8 ? 2'b10 : len == 5'd4 ? 2'b01 : 2'b00;
    done            = state == DONE;
    error           = state == ERR;
  end
  // word buffer storage; emptiness is tracked by cnt so no reset is needed
  always_ff @(posedge clock) begin
    if (accept) buffer[cnt[3:0]] <= word_in;
  end
  // fill count, read offset, beat counter, write pointer and commit count
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt           <= '0;
      rd            <= '0;
      beat          <= '0;
      len           <= '0;
      last_seen     <= 1'b0;
      ptr           <= START_ADDR;
      words_written <= '0;
    end else begin
      if (restart) begin
        cnt           <= '0;
        rd            <= '0;
        last_seen     <= 1'b0;
        ptr           <= START_ADDR;
        words_written <= '0;
      end
      if (accept) begin
        cnt       <= cnt + 5'd1;
        last_seen <= word_last;
      end
      if (launch) begin
        len  <= len_nx;
        beat <= '0;
      end
      if (beat_done) beat <= beat + 4'd1;
      if (burst_end) begin
        cnt           <= cnt - len;
        rd            <= rd + len[3:0];
        ptr           <= ptr + (ADDR_WIDTH'(len) << 2);
        words_written <= words_written + ADDR_WIDTH'(len);
      end
    end
  end
`ifdef LOADER_CHECKSUM_EN
  // running sum of committed words, restarted with each load
  always_ff @(posedge clock) begin
    if (reset || restart) checksum <= '0;
    else if (beat_done) checksum <= checksum + mem_data_in;
  end
`endif
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: randomized bench checking mem_loader write bursts against a burst-plan reference model
module tb_mem_loader;
  localparam int          DEPTH = 20;
  localparam logic [31:0] BASE  = 32'h80020000;
  typedef struct packed {logic [31:0] addr; logic [1:0] size; logic [31:0] data; logic rw;} beat_t;
  logic        clk = 0, rst = 1, start = 0, word_valid = 0, word_last = 0, mem_busy = 0;
  logic [31:0] word_in = 0;
  logic        word_ready, mem_rw, mem_enable, done, error;
  logic [31:0] mem_address, mem_data_in, words_written;
  logic [1:0]  mem_access_size;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif
  beat_t       beats[$], exp_q[$];
  logic [31:0] img [64];
  int          total = 0, bad = 0, busy_mode = 0, hold = 0, d6 = 0, freeze_bad = 0, rw_bad = 0;
  bit          exp_err;
  int          exp_ww;
  logic [31:0] exp_sum;

  mem_loader #(.DEPTH_WORDS(DEPTH)) dut (
    .clock(clk), .reset(rst), .start(start), .word_in(word_in), .word_valid(word_valid),
    .word_last(word_last), .word_ready(word_ready), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_access_size(mem_access_size), .mem_rw(mem_rw),
    .mem_enable(mem_enable), .mem_busy(mem_busy), .done(done), .error(error),
    .words_written(words_written)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  initial forever #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (busy_mode == 1) mem_busy = $urandom_range(0, 3) == 0;
    else if (busy_mode == 2 && beats.size() == 5 && hold < 3) begin
      mem_busy = 1;
      hold++;
    end else mem_busy = 0;
  end

  initial begin
    logic [67:0] snap, prev_snap;
    bit prev_hold;
    prev_hold = 0;
    prev_snap = '0;
    forever begin
      @(negedge clk);
      snap = {mem_enable, mem_rw, mem_access_size, mem_address, mem_data_in};
      if (!rst && prev_hold && snap !== prev_snap) freeze_bad++;
      if (!rst && mem_rw !== !mem_enable) rw_bad++;
      if (!rst && mem_enable && !mem_busy) beats.push_back({mem_address, mem_access_size, mem_data_in, mem_rw});
      if (!rst && mem_enable && mem_data_in == 32'd6) d6++;
      prev_hold = !rst && mem_enable && mem_busy;
      prev_snap = snap;
    end
  end

  task automatic build_model(input int n);
    int pos, len;
    pos = 0;
    exp_q.delete();
    exp_err = 0;
    exp_sum = 0;
    while (pos < n) begin
      len = (n - pos >= 16) ? 16 : (n - pos >= 8) ? 8 : (n - pos >= 4) ? 4 : 1;
      if (pos + len > DEPTH) begin
        exp_err = 1;
        break;
      end
      for (int i = 0; i < len; i++) begin
        exp_q.push_back({BASE + 32'(4 * pos), len == 16 ? 2'd3 : len == 8 ? 2'd2 : len == 4 ? 2'd1 : 2'd0, img[pos + i], 1'b0});
        exp_sum += img[pos + i];
      end
      pos += len;
    end
    exp_ww = pos;
  endtask

  task automatic do_reset;
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic pulse_start;
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic run_load(input int n, input int gap, input int stop_at);
    int idx, cyc;
    bit acc;
    idx = 0;
    cyc = 0;
    beats.delete();
    freeze_bad = 0;
    rw_bad = 0;
    d6 = 0;
    hold = 0;
    pulse_start();
    word_valid = $urandom_range(0, 99) >= gap;
    word_in = img[0];
    word_last = n == 1;
    while (idx < n && !error && cyc < 4000) begin
      @(negedge clk);
      acc = word_valid && word_ready;
      @(posedge clk);
      #1 cyc++;
      if (acc) idx++;
      word_valid = idx < n && $urandom_range(0, 99) >= gap;
      word_in = idx < n ? img[idx] : 32'd0;
      word_last = idx == n - 1;
    end
    word_valid = 0;
    word_last = 0;
    while (cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (done || error || (stop_at > 0 && beats.size() >= stop_at)) break;
    end
    if (cyc >= 4000) begin
      total++;
      bad++;
      $display("FAIL timeout n=%0d accepted=%0d beats=%0d", n, idx, beats.size());
    end
  endtask

  task automatic test_reset;
    @(posedge clk);
    @(posedge clk);
    #1;
    total += 9;
    if (word_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", word_ready); end
    if (mem_enable !== 1'b0) begin bad++; $display("FAIL rst_enable got=%b want=0", mem_enable); end
    if (mem_rw !== 1'b1) begin bad++; $display("FAIL rst_rw got=%b want=1", mem_rw); end
    if (mem_address !== BASE) begin bad++; $display("FAIL rst_addr got=%h want=%h", mem_address, BASE); end
    if (mem_data_in !== 32'd0) begin bad++; $display("FAIL rst_data got=%h want=0", mem_data_in); end
    if (mem_access_size !== 2'b00) begin bad++; $display("FAIL rst_size got=%b want=00", mem_access_size); end
    if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
    if (error !== 1'b0) begin bad++; $display("FAIL rst_error got=%b want=0", error); end
    if (words_written !== 32'd0) begin bad++; $display("FAIL rst_ww got=%0d want=0", words_written); end
    rst = 0;
  endtask

  task automatic test_full_burst;
    for (int i = 0; i < 16; i++) img[i] = i + 1;
    busy_mode = 0;
    run_load(16, 0, 0);
    total++;
    if (beats.size() != 16) begin bad++; $display("FAIL full_count got=%0d want=16", beats.size()); end
    for (int i = 0; i < beats.size() && i < 16; i++) begin
      total++;
      if (beats[i] !== {BASE, 2'b11, 32'(i + 1), 1'b0}) begin
        bad++;
        $display("FAIL full_beat%0d got=%h/%b/%h/%b want=%h/11/%h/0", i, beats[i].addr, beats[i].size, beats[i].data, beats[i].rw, BASE, i + 1);
      end
    end
    total += 2;
    if (done !== 1'b1) begin bad++; $display("FAIL full_done got=%b want=1", done); end
    if (words_written !== 32'd16) begin bad++; $display("FAIL full_ww got=%0d want=16", words_written); end
  endtask

  task automatic test_flush;
    logic [31:0] a;
    logic [1:0] s;
    for (int i = 0; i < 13; i++) img[i] = $urandom;
    run_load(13, 30, 0);
    total++;
    if (beats.size() != 13) begin bad++; $display("FAIL flush_count got=%0d want=13", beats.size()); end
    for (int i = 0; i < beats.size() && i < 13; i++) begin
      a = i < 8 ? 32'h80020000 : i < 12 ? 32'h80020020 : 32'h80020030;
      s = i < 8 ? 2'b10 : i < 12 ? 2'b01 : 2'b00;
      total++;
      if (beats[i] !== {a, s, img[i], 1'b0}) begin
        bad++;
        $display("FAIL flush_beat%0d got=%h/%b/%h want=%h/%b/%h", i, beats[i].addr, beats[i].size, beats[i].data, a, s, img[i]);
      end
    end
    total += 2;
    if (done !== 1'b1) begin bad++; $display("FAIL flush_done got=%b want=1", done); end
    if (words_written !== 32'd13) begin bad++; $display("FAIL flush_ww got=%0d want=13", words_written); end
  endtask

  task automatic test_busy_stall;
    for (int i = 0; i < 16; i++) img[i] = i + 1;
    busy_mode = 2;
    run_load(16, 0, 0);
    busy_mode = 0;
    total += 4;
    if (beats.size() != 16) begin bad++; $display("FAIL stall_count got=%0d want=16", beats.size()); end
    if (d6 != 4) begin bad++; $display("FAIL stall_hold6 got=%0d want=4", d6); end
    if (freeze_bad != 0) begin bad++; $display("FAIL stall_freeze got=%0d want=0", freeze_bad); end
    if (done !== 1'b1) begin bad++; $display("FAIL stall_done got=%b want=1", done); end
    for (int i = 0; i < beats.size() && i < 16; i++) begin
      total++;
      if (beats[i].data !== 32'(i + 1)) begin bad++; $display("FAIL stall_beat%0d got=%h want=%h", i, beats[i].data, i + 1); end
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 40; i++) img[i] = $urandom;
    run_load(40, 0, 0);
    repeat (3) @(negedge clk);
    total += 5;
    if (beats.size() != 16) begin bad++; $display("FAIL ovf_count got=%0d want=16", beats.size()); end
    if (error !== 1'b1) begin bad++; $display("FAIL ovf_error got=%b want=1", error); end
    if (done !== 1'b0) begin bad++; $display("FAIL ovf_done got=%b want=0", done); end
    if (words_written !== 32'd16) begin bad++; $display("FAIL ovf_ww got=%0d want=16", words_written); end
    if (mem_enable !== 1'b0 || word_ready !== 1'b0) begin bad++; $display("FAIL ovf_idle got=%b%b want=00", mem_enable, word_ready); end
    do_reset();
  endtask

  task automatic test_reset_mid_burst;
    for (int i = 0; i < 16; i++) img[i] = $urandom;
    run_load(16, 0, 7);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1;
    total += 4;
    if (mem_enable !== 1'b0) begin bad++; $display("FAIL midrst_enable got=%b want=0", mem_enable); end
    if (mem_rw !== 1'b1) begin bad++; $display("FAIL midrst_rw got=%b want=1", mem_rw); end
    if (words_written !== 32'd0) begin bad++; $display("FAIL midrst_ww got=%0d want=0", words_written); end
    if (mem_address !== BASE) begin bad++; $display("FAIL midrst_addr got=%h want=%h", mem_address, BASE); end
    rst = 0;
    for (int i = 0; i < 16; i++) img[i] = $urandom;
    build_model(16);
    run_load(16, 20, 0);
    total++;
    if (beats.size() != exp_q.size()) begin bad++; $display("FAIL reload_count got=%0d want=%0d", beats.size(), exp_q.size()); end
    for (int i = 0; i < beats.size() && i < exp_q.size(); i++) begin
      total++;
      if (beats[i] !== exp_q[i]) begin bad++; $display("FAIL reload_beat%0d got=%h want=%h", i, beats[i], exp_q[i]); end
    end
    total += 2;
    if (done !== 1'b1) begin bad++; $display("FAIL reload_done got=%b want=1", done); end
    if (words_written !== 32'd16) begin bad++; $display("FAIL reload_ww got=%0d want=16", words_written); end
  endtask

  task automatic test_random;
    for (int t = 0; t < 14; t++) begin
      int n;
      n = (t % 4 == 3) ? $urandom_range(21, 40) : $urandom_range(1, 20);
      for (int i = 0; i < n; i++) img[i] = $urandom;
      build_model(n);
      busy_mode = 1;
      run_load(n, $urandom_range(0, 50), 0);
      busy_mode = 0;
      repeat (2) @(negedge clk);
      total++;
      if (beats.size() != exp_q.size()) begin bad++; $display("FAIL rand%0d_count n=%0d got=%0d want=%0d", t, n, beats.size(), exp_q.size()); end
      for (int i = 0; i < beats.size() && i < exp_q.size(); i++) begin
        total++;
        if (beats[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_beat%0d got=%h want=%h", t, i, beats[i], exp_q[i]); end
      end
      total += 5;
      if (done !== !exp_err) begin bad++; $display("FAIL rand%0d_done got=%b want=%b", t, done, !exp_err); end
      if (error !== exp_err) begin bad++; $display("FAIL rand%0d_error got=%b want=%b", t, error, exp_err); end
      if (words_written !== 32'(exp_ww)) begin bad++; $display("FAIL rand%0d_ww got=%0d want=%0d", t, words_written, exp_ww); end
      if (freeze_bad != 0) begin bad++; $display("FAIL rand%0d_freeze got=%0d want=0", t, freeze_bad); end
      if (rw_bad != 0) begin bad++; $display("FAIL rand%0d_rw got=%0d want=0", t, rw_bad); end
`ifdef LOADER_CHECKSUM_EN
      total++;
      if (checksum !== exp_sum) begin bad++; $display("FAIL rand%0d_checksum got=%h want=%h", t, checksum, exp_sum); end
`endif
      if (error) do_reset();
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum;
    for (int i = 0; i < 16; i++) img[i] = i + 1;
    run_load(16, 0, 0);
    repeat (3) @(negedge clk);
    total++;
    if (checksum !== 32'h88) begin bad++; $display("FAIL cks_done got=%h want=00000088", checksum); end
    pulse_start();
    total += 2;
    if (checksum !== 32'h0) begin bad++; $display("FAIL cks_clear got=%h want=0", checksum); end
    if (done !== 1'b0) begin bad++; $display("FAIL cks_done_clear got=%b want=0", done); end
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_full_burst();
    test_flush();
    test_busy_stall();
    test_overflow();
    test_reset_mid_burst();
    test_random();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
